pipe_stage_elastic: RTL and testbench
=====================================

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 160, datapath payload width in bits (operands, immediate, PC, IR, register indices).
REQ-002 SHALL have parameter CTRL_W, default 12, control payload width in bits (RegWrite, MemRead, ALUOp, Branch, Predict, ...).
REQ-003 SHALL have parameter CNT_W, default 16, bubble counter width in bits.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports in_valid_i input 1, data_i input DATA_W, ctrl_i input CTRL_W: upstream payload offer.
REQ-007 SHALL have port in_ready_o  output  1  stage accepts upstream payload this cycle.
REQ-008 SHALL have ports out_valid_o output 1, data_o output DATA_W, ctrl_o output CTRL_W: downstream payload offer.
REQ-009 SHALL have port out_ready_i  input  1  downstream accepts payload this cycle.
REQ-010 SHALL have port flush_i  input  1  kill all held payloads (branch mispredict).
REQ-011 SHALL have port stall_i  input  1  freeze stage, present bubble downstream (load-use hazard).
REQ-012 SHALL have port bubble_cnt_o  output  CNT_W  count of bubble cycles.

Function
REQ-013 SHALL transfer in on in_valid_i & in_ready_o and out on out_valid_o & out_ready_i at the rising edge of clk_i.
REQ-014 SHALL give one-cycle latency from accepted input to out_valid_o and sustain one transfer per cycle when out_ready_i=1.
REQ-015 SHALL apply priority flush_i > stall_i > normal handshake when asserted together.
REQ-016 SHALL on flush_i clear every entry's valid bit and ctrl field to 0 at the next edge, leave data fields unchanged, hold in_ready_o=1, and discard the input offered that cycle.
REQ-017 SHALL while stall_i=1 (flush_i=0) force in_ready_o=0 and out_valid_o=0 combinationally and hold all entries unchanged.
REQ-018 SHALL output ctrl_o=0 whenever out_valid_o=0, so downstream control is a clean bubble.
REQ-019 SHALL increment bubble_cnt_o by 1 on each edge where stall_i|flush_i=1, saturating at all-ones (no wrap).
REQ-020 SHALL deliver payloads in acceptance order; no payload is duplicated or lost except by flush_i.

Reset
REQ-021 SHALL, while rst_i=0, immediately drive out_valid_o=0, ctrl_o=0, data_o=0, bubble_cnt_o=0, clear all entries, and keep in_ready_o=0.
REQ-022 SHALL, on reset assertion mid-transfer, drop the payload in flight; first acceptance possible on the first edge after rst_i rises.

Configuration
REQ-023 SHALL, with PIPE_STAGE_SKID_EN undefined, hold one entry and drive in_ready_o = ~stall_i & (out_ready_i | ~out_valid_o) (combinational ready path).
REQ-024 SHALL, with PIPE_STAGE_SKID_EN defined, hold a main plus a skid entry and drive in_ready_o = ~stall_i & ~skid_valid, with skid_valid a flop (no combinational out_ready_i->in_ready_o path).
REQ-025 SHALL, in skid mode, load the skid entry when input is accepted while the main entry is valid and not draining, promote skid to main on drain, and keep REQ-014 latency and throughput.

Structure
REQ-026 SHALL place default widths, the ctrl bit-field index constants and the bubble-ctrl zero constant in the shared pipeline package.
REQ-027 SHALL implement the skid storage as one sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-028 SHALL cover streaming: 8 payloads data_i=1..8, out_ready_i=1 -> data_o=1..8 on consecutive cycles, each one cycle after acceptance.
REQ-029 SHALL cover backpressure: out_ready_i=0 for 3 cycles mid-stream -> no loss or duplication; skid mode accepts exactly one extra payload, then in_ready_o=0.
REQ-030 SHALL cover flush: flush_i=1 with valid entries and in_valid_i=1 -> next cycle out_valid_o=0, ctrl_o=0, input discarded, bubble_cnt_o +1.
REQ-031 SHALL cover stall: stall_i=1 for 2 cycles holding data 0xA5 -> out_valid_o=0 both cycles, then 0xA5 presented once, bubble_cnt_o +2.
REQ-032 SHALL cover saturation and reset: CNT_W=4 with 20 stall cycles -> bubble_cnt_o=15; rst_i=0 mid-stream -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the elastic pipeline stage: default widths, ctrl bit-field map,
// the bubble ctrl value and the flush/stall/run priority decode.
package pipe_stage_elastic_pkg;

    localparam int DATA_W_DEF = 160;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    // Ctrl payload bit-field map, as seen by downstream stages
    localparam int CTRL_REGWRITE_BIT = 0;
    localparam int CTRL_MEMREAD_BIT  = 1;
    localparam int CTRL_MEMWRITE_BIT = 2;
    localparam int CTRL_ALUOP_LSB    = 3;
    localparam int CTRL_ALUOP_MSB    = 6;
    localparam int CTRL_BRANCH_BIT   = 7;
    localparam int CTRL_PREDICT_BIT  = 8;
    localparam int CTRL_JUMP_BIT     = 9;
    localparam int CTRL_MEMTOREG_BIT = 10;
    localparam int CTRL_ALUSRC_BIT   = 11;

    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_STALL = 2'd1,
        OP_FLUSH = 2'd2
    } stage_op_e;

    function automatic stage_op_e decode_op(input logic flush, input logic stall);
        if (flush) begin
            return OP_FLUSH;
        end
        if (stall) begin
            return OP_STALL;
        end
        return OP_RUN;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single skid entry for pipe_stage_elastic; only exists when PIPE_STAGE_SKID_EN is defined.
// Flush clears valid and ctrl but keeps data; load and pop are never requested together.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_W'(CTRL_BUBBLE);
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule
`endif

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with flush/stall and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and cut the out_ready_i -> in_ready_o path.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    stage_op_e         op;
    logic              in_fire;
    logic              out_fire;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    assign op = decode_op(flush_i, stall_i);

    // Held payloads are never offered downstream while being killed or frozen
    assign out_valid_o  = main_valid_q & (op == OP_RUN);
    assign data_o       = main_data_q;
    assign ctrl_o       = out_valid_o ? main_ctrl_q : CTRL_W'(CTRL_BUBBLE);
    assign bubble_cnt_o = bubble_cnt_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_pop;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign in_ready_o = rst_i & ((op == OP_FLUSH) | ((op == OP_RUN) & ~skid_valid));

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (op == OP_FLUSH),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .data_i  (data_i),
        .ctrl_i  (ctrl_i),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_load    = 1'b0;
        skid_pop     = 1'b0;
        case (op)
            OP_FLUSH: begin
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_W'(CTRL_BUBBLE);
            end
            OP_STALL: begin
            end
            default: begin
                // in_ready_o is low while the skid is full, so no input arrives here then
                if (skid_valid) begin
                    if (out_fire) begin
                        main_data_d = skid_data;
                        main_ctrl_d = skid_ctrl;
                        skid_pop    = 1'b1;
                    end
                end else if (in_fire && main_valid_q && !out_fire) begin
                    skid_load = 1'b1;
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = data_i;
                    main_ctrl_d  = ctrl_i;
                end else if (out_fire) begin
                    main_valid_d = 1'b0;
                end
            end
        endcase
    end
`else
    assign in_ready_o = rst_i & ((op == OP_FLUSH) |
                                 ((op == OP_RUN) & (out_ready_i | ~main_valid_q)));

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        case (op)
            OP_FLUSH: begin
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_W'(CTRL_BUBBLE);
            end
            OP_STALL: begin
            end
            default: begin
                if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = data_i;
                    main_ctrl_d  = ctrl_i;
                end else if (out_fire) begin
                    main_valid_d = 1'b0;
                end
            end
        endcase
    end
`endif

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((op != OP_RUN) && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (default and PIPE_STAGE_SKID_EN builds).
module tb_pipe_stage_elastic;

    localparam int DW = 160;
    localparam int CW = 12;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic [CW-1:0] ctrl_in;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ctrl_out;
    logic          out_ready;
    logic          flush;
    logic          stall;
    logic [NW-1:0] bubble_cnt;

    logic          sat_in_ready;
    logic          sat_out_valid;
    logic [7:0]    sat_data_out;
    logic [3:0]    sat_ctrl_out;
    logic          sat_stall;
    logic [3:0]    sat_bubble_cnt;

    int errors = 0;
    int checks = 0;
    int exp_bubble = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .in_valid_i   (in_valid),
        .data_i       (data_in),
        .ctrl_i       (ctrl_in),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .data_o       (data_out),
        .ctrl_o       (ctrl_out),
        .out_ready_i  (out_ready),
        .flush_i      (flush),
        .stall_i      (stall),
        .bubble_cnt_o (bubble_cnt)
    );

    pipe_stage_elastic #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dut_sat (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .in_valid_i   (1'b0),
        .data_i       (8'h00),
        .ctrl_i       (4'h0),
        .in_ready_o   (sat_in_ready),
        .out_valid_o  (sat_out_valid),
        .data_o       (sat_data_out),
        .ctrl_o       (sat_ctrl_out),
        .out_ready_i  (1'b1),
        .flush_i      (1'b0),
        .stall_i      (sat_stall),
        .bubble_cnt_o (sat_bubble_cnt)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backpressure vectors: out_ready per cycle and the hand-derived in_ready/out_valid
    logic bp_ordy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic bp_ovalid [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef PIPE_STAGE_SKID_EN
    logic bp_irdy   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic bp_irdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] next_in;
        int            accepted;
        int            delivered;

        rst_n = 1'b0; in_valid = 1'b1; data_in = '0; ctrl_in = '0;
        out_ready = 1'b0; flush = 1'b0; stall = 1'b0; sat_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", DW'(out_valid), DW'(0));
        check_eq("rst_in_ready", DW'(in_ready), DW'(0));
        check_eq("rst_bubble", DW'(bubble_cnt), DW'(0));
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Streaming 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; data_in = DW'(k); ctrl_in = CW'(k);
            #1;
            check_eq($sformatf("stream_rdy%0d", k), DW'(in_ready), DW'(1));
            if (k > 1) begin
                check_eq($sformatf("stream_valid%0d", k - 1), DW'(out_valid), DW'(1));
                check_eq($sformatf("stream_data%0d", k - 1), data_out, DW'(k - 1));
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check_eq("stream_valid8", DW'(out_valid), DW'(1));
        check_eq("stream_data8", data_out, DW'(8));
        check_eq("stream_ctrl8", DW'(ctrl_out), DW'(8));
        step();
        check_eq("stream_empty", DW'(out_valid), DW'(0));
        check_eq("stream_empty_ctrl", DW'(ctrl_out), DW'(0));

        // Backpressure: out_ready low for three cycles while input keeps offering
        next_in = DW'('h11);
        accepted = 0;
        delivered = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1; data_in = next_in; ctrl_in = CW'('h1);
            out_ready = bp_ordy[c];
            #1;
            check_eq($sformatf("bp_rdy_c%0d", c), DW'(in_ready), DW'(bp_irdy[c]));
            check_eq($sformatf("bp_valid_c%0d", c), DW'(out_valid), DW'(bp_ovalid[c]));
            if (out_valid && out_ready) begin
                check_eq($sformatf("bp_data_c%0d", c), data_out,
                         (exp_q.size() > 0) ? exp_q[0] : DW'(0));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                delivered++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(next_in);
                next_in = next_in + DW'(1);
                accepted++;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (out_valid) begin
                check_eq($sformatf("bp_drain%0d", c), data_out,
                         (exp_q.size() > 0) ? exp_q[0] : DW'(0));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                delivered++;
            end
            step();
        end
        check_eq("bp_accepted", DW'(accepted), DW'(4));
        check_eq("bp_delivered", DW'(delivered), DW'(4));

        // Flush with a held entry and a competing input offer
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = DW'('h33); ctrl_in = CW'('h5A);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("flush_pre_valid", DW'(out_valid), DW'(1));
        check_eq("flush_pre_ctrl", DW'(ctrl_out), DW'('h5A));
        in_valid = 1'b1; data_in = DW'('h77); ctrl_in = CW'('h0F); flush = 1'b1;
        #1;
        check_eq("flush_rdy", DW'(in_ready), DW'(1));
        step();
        exp_bubble++;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("flush_valid", DW'(out_valid), DW'(0));
        check_eq("flush_ctrl", DW'(ctrl_out), DW'(0));
        check_eq("flush_data_kept", data_out, DW'('h33));
        check_eq("flush_bubble", DW'(bubble_cnt), DW'(exp_bubble));
        out_ready = 1'b1;
        step();
        check_eq("flush_input_dropped", DW'(out_valid), DW'(0));

        // Stall for two cycles holding 0xA5
        in_valid = 1'b1; data_in = DW'('hA5); ctrl_in = CW'('h3C);
        step();
        data_in = DW'('h11); stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_eq($sformatf("stall_valid%0d", c), DW'(out_valid), DW'(0));
            check_eq($sformatf("stall_rdy%0d", c), DW'(in_ready), DW'(0));
            check_eq($sformatf("stall_ctrl%0d", c), DW'(ctrl_out), DW'(0));
            step();
            exp_bubble++;
        end
        stall = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("stall_release_valid", DW'(out_valid), DW'(1));
        check_eq("stall_release_data", data_out, DW'('hA5));
        check_eq("stall_release_ctrl", DW'(ctrl_out), DW'('h3C));
        check_eq("stall_bubble", DW'(bubble_cnt), DW'(exp_bubble));
        step();
        check_eq("stall_once", DW'(out_valid), DW'(0));

        // Saturation on the 4-bit counter instance
        sat_stall = 1'b1;
        repeat (14) step();
        check_eq("sat_14", DW'(sat_bubble_cnt), DW'(14));
        repeat (6) step();
        check_eq("sat_20", DW'(sat_bubble_cnt), DW'(15));
        sat_stall = 1'b0;
        check_eq("sat_out_valid", DW'(sat_out_valid), DW'(0));

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = DW'('h99); ctrl_in = CW'('h7);
        step();
        check_eq("arst_pre_valid", DW'(out_valid), DW'(1));
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", DW'(out_valid), DW'(0));
        check_eq("arst_data", data_out, DW'(0));
        check_eq("arst_ctrl", DW'(ctrl_out), DW'(0));
        check_eq("arst_bubble", DW'(bubble_cnt), DW'(0));
        check_eq("arst_rdy", DW'(in_ready), DW'(0));
        check_eq("arst_sat_bubble", DW'(sat_bubble_cnt), DW'(0));
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; data_in = DW'('h42); ctrl_in = CW'('h1);
        #1;
        check_eq("post_rst_rdy", DW'(in_ready), DW'(1));
        step();
        in_valid = 1'b0;
        #1;
        check_eq("post_rst_valid", DW'(out_valid), DW'(1));
        check_eq("post_rst_data", data_out, DW'('h42));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
